md_unit: RTL and testbench

- Iterative multiply/divide unit that produces the 64-bit HI/LO result pair for MULT, MULTU, DIV and DIVU.
- Sits in EX beside the ALU. Its RES_HI/RES_LO/DONE outputs drive the HI/LO register's DHi/DLo/EN inputs directly.
- The pipeline control sees BUSY and stalls any MFHI/MFLO or new mult/div while it is high.

---
 rtl/md_unit.sv | 175 +++++++++++++++++
 tb/tb_md_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide unit producing the HI/LO result pair.
//   Signed and unsigned multiply use shift-add on a 2W-bit accumulator.
//   Signed and unsigned divide use restoring division.
//   Signed operations run on operand magnitudes, and the signs are applied in one final cycle.
// Ports:
//   CLK, RST_N      clock and synchronous active-low reset
//   START, OP, A, B request (START is sampled in IDLE only), op code, operands
//   FLUSH           abandons an operation that is in CALC or SIGN
//   RES_HI, RES_LO  registered result (product or remainder, quotient)
//   BUSY            high in every non-IDLE state
//   DONE            one-cycle pulse in FIN; used as the HI/LO write enable
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] RES_HI,
  output logic [WIDTH-1:0] RES_LO,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, FIN} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, a_raw_q, a_raw_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic               busy_q, busy_d, done_q, done_d;

  // Magnitude is formed in W+1 bits so that |most-negative| survives.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
    logic signed [WIDTH:0] ext;
    logic signed [WIDTH:0] neg;
    ext = {x[WIDTH-1], x};
    neg = -ext;
    return (is_signed && x[WIDTH-1]) ? neg[WIDTH-1:0] : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    a_raw_d  = a_raw_q;
    acc_d    = acc_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    a_mag    = mag(A, ~OP[0]);
    b_mag    = mag(B, ~OP[0]);
    // Multiply step: conditionally add the multiplicand to the high half, then shift right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide step: shift in the next dividend bit, then trial-subtract.
    // A borrow (bit W set) means restore.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    prod = acc_q;
    quo  = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];

    unique case (state_q)
      IDLE: begin
        if (START) begin
          op_d    = OP;
          neg_a_d = ~OP[0] & A[WIDTH-1];
          neg_b_d = ~OP[0] & B[WIDTH-1];
          dz_d    = (B == '0);
          a_raw_d = A;
          // The accumulator's low half holds the shifting operand.
          // That is the multiplier for a multiply and the dividend for a divide.
          acc_d   = OP[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          opnd_d  = OP[1] ? b_mag : a_mag;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (op_q[1]) begin
          if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (FLUSH)
          state_d = IDLE;
        else if (cnt_q == CW'(WIDTH - 1))
          state_d = SIGN;
      end
      SIGN: begin
        if (FLUSH) begin
          state_d = IDLE;
        end else begin
          if (op_q[1]) begin
            if (neg_a_q ^ neg_b_q) quo = neg_w(quo);
            if (neg_a_q)           rem = neg_w(rem);
            res_lo_d = dz_q ? '1 : quo;
            res_hi_d = dz_q ? a_raw_q : rem;
          end else begin
            if (neg_a_q ^ neg_b_q) prod = neg_2w(prod);
            res_hi_d = prod[2*WIDTH-1:WIDTH];
            res_lo_d = prod[WIDTH-1:0];
          end
          state_d = FIN;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    op_q    <= op_d;
    neg_a_q <= neg_a_d;
    neg_b_q <= neg_b_d;
    dz_q    <= dz_d;
    opnd_q  <= opnd_d;
    a_raw_q <= a_raw_d;
    acc_q   <= acc_d;
  end

  assign RES_HI = res_hi_q;
  assign RES_LO = res_lo_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [1:0]  op;
  logic [31:0] a, b, res_hi, res_lo;
  logic        busy, done;

  md_unit #(.WIDTH(32)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .OP(op), .A(a), .B(b), .FLUSH(flush),
    .RES_HI(res_hi), .RES_LO(res_lo), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          at;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every DONE pulse pops one expected result and checks values and latency.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got DONE=1 expected no DONE (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("res_hi", {32'h0, res_hi}, {32'h0, e.hi});
        chk("res_lo", {32'h0, res_lo}, {32'h0, e.lo});
        chk("done_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  // Called just after a negedge. START is sampled at the next edge N.
  // DONE is then expected to be seen at the negedge after edge N+33.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo,
                       input bit hold, input bit poke, input bit fl);
    exp_t e;
    op = o; a = x; b = y; start = 1'b1; flush = fl;
    e.hi = ehi; e.lo = elo; e.at = cyc + 34;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 1'b0;
    flush = 1'b0;
    chk("busy_after_start", {63'h0, busy}, 64'h1);
    for (int k = 0; k < 60 && busy; k++) begin
      if (poke && k == 5) begin start = 1'b1; op = 2'b11; a = 32'h0000DEAD; b = 32'h3; end
      if (poke && k == 6) start = 1'b0;
      if (hold && done) start = 1'b0;
      @(negedge clk);
    end
    chk("idle_after_op", {62'h0, busy, done}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    chk("reset_res", {res_hi, res_lo}, 64'h0);

    // Reset in the middle of MULTU 5x7: the operation is discarded and no DONE follows.
    op = 2'b01; a = 32'd5; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_busy", {63'h0, busy}, 64'h0);
    chk("midreset_res", {res_hi, res_lo}, 64'h0);
    repeat (30) @(negedge clk);
    chk("midreset_still_idle", {62'h0, busy, done}, 64'h0);

    do_op(2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 0);
    do_op(2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 0, 0, 0);
    do_op(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
    do_op(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 0, 0, 0);
    do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 0, 0);
    do_op(2'b11, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0);
    do_op(2'b10, 32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFF, 0, 0, 0);
    do_op(2'b10, 32'd100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 0, 0, 0);

    // START held through a whole operation, then a new START accepted at N+35.
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1, 0, 0);
    do_op(2'b11, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 0, 0, 0);
    // START pulses during CALC are ignored.
    do_op(2'b00, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 0, 1, 0);

    // FLUSH sampled at edge N+10 of MULTU 3x4.
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'h0, busy}, 64'h0);
    chk("flush_res_kept", {res_hi, res_lo}, 64'hFFFFFFFF_80000001);
    repeat (30) @(negedge clk);
    chk("flush_res_still_kept", {res_hi, res_lo}, 64'hFFFFFFFF_80000001);

    // FLUSH together with START in IDLE: START wins.
    do_op(2'b01, 32'd3, 32'd4, 32'h00000000, 32'h0000000C, 0, 0, 1);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
